// File: rtl/imem_loader_ctrl_pkg.sv
// imem_loader_ctrl_pkg: shared core definitions for the instruction-memory loader.
//   BUNDLE_W - width of one instruction-memory bundle (two 32-bit words)
//   NOP      - instruction word used to pad an odd-length program
//   state_t  - loader controller states
package imem_loader_ctrl_pkg;
    localparam int BUNDLE_W = 64;
    localparam logic [31:0] NOP = {3'b111, 29'b0};
    typedef enum logic [1:0] {S_LOAD, S_FLUSH, S_RUN} state_t;
endpackage

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: packs a 32-bit loader word stream into 64-bit instruction-memory
// bundles, then releases the core from reset after a short BRAM flush.
//   clk, rstn              - clock, synchronous active-low reset
//   ld_valid/ld_data/ld_last/ld_ready - loader word stream (handshake)
//   reload                 - single-cycle request to re-enter load mode
//   fetch_addr             - bundle index requested by fetch while running
//   mem_addr/mem_we/mem_din - BRAM byte address, write enable, write data
//   core_rstn              - active-low reset to fetch and the pipeline
//   overflow               - sticky: program reached the memory depth
//   bundle_count           - bundles written in the last load (saturating)
import imem_loader_ctrl_pkg::*;

module imem_loader_ctrl #(
    parameter int DEPTH_LOG2 = 13
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ld_valid,
    input  logic [31:0]           ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    input  logic                  reload,
    input  logic [31:0]           fetch_addr,
    output logic [31:0]           mem_addr,
    output logic                  mem_we,
    output logic [BUNDLE_W-1:0]   mem_din,
    output logic                  core_rstn,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   bundle_count
);
    state_t              r_state, w_next;
    logic [DEPTH_LOG2:0] r_wptr;
    logic [31:0]         r_hold;
    logic [31:0]         w_idx;
    logic                r_half, r_overflow, r_flush;
    logic                w_load, w_accept, w_write, w_full;

    always_comb begin
        w_load       = rstn && r_state == S_LOAD;
        w_full       = r_wptr[DEPTH_LOG2];
        ld_ready     = w_load && !reload;
        w_accept     = ld_ready && ld_valid;
        // Once full, the loader keeps draining but nothing more is written.
        w_write      = w_accept && (r_half || ld_last) && !w_full;
        mem_we       = w_write;
        mem_din      = !w_write ? '0 : r_half ? {r_hold, ld_data} : {ld_data, NOP};
        w_idx        = !rstn ? 32'd0 : r_state == S_LOAD ? 32'(r_wptr) :
                       r_state == S_RUN ? fetch_addr : 32'd0;
        mem_addr     = w_idx << 3;
        core_rstn    = rstn && r_state == S_RUN;
        overflow     = r_overflow;
        bundle_count = r_wptr;
        w_next       = r_state;
        if (reload)
            w_next = S_LOAD;
        else if (r_state == S_LOAD && w_accept && ld_last)
            w_next = S_FLUSH;
        else if (r_state == S_FLUSH && r_flush)
            w_next = S_RUN;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_LOAD;
            r_wptr     <= '0;
            r_hold     <= '0;
            r_half     <= 1'b0;
            r_overflow <= 1'b0;
            r_flush    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (reload) begin
                r_wptr     <= '0;
                r_half     <= 1'b0;
                r_overflow <= 1'b0;
                r_flush    <= 1'b0;
            end else begin
                if (w_accept && !r_half)
                    r_hold <= ld_data;
                if (w_accept)
                    r_half <= !r_half && !ld_last;
                if (w_write)
                    r_wptr <= r_wptr + 1'b1;
                // Set on the write that brings the pointer to the full depth.
                if (w_write && &r_wptr[DEPTH_LOG2-1:0])
                    r_overflow <= 1'b1;
                // Second FLUSH cycle is marked so FLUSH lasts exactly two cycles.
                r_flush <= r_state == S_FLUSH && !r_flush;
            end
        end
    end
endmodule
